// File: rtl/seq_div_2bit.sv
// Sequential restoring divider: quotient and remainder of a/b, one quotient bit per clock, MSB first.
// Latency: done in the cycle after WIDTH+1 edges from the start-sampling edge (1 edge when b==0).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
module seq_div_2bit #(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               PB0,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Working registers of the division in flight.
  logic [WIDTH-1:0] r_dvd;       // dividend, shifted left each step
  logic [WIDTH-1:0] r_dvs;       // captured divisor
  logic [WIDTH:0]   r_prem;      // partial remainder, one bit wider so the compare cannot overflow
  logic [WIDTH-1:0] r_quo_work;  // quotient bits collected so far
  logic [CW-1:0]    r_cnt;       // steps still to perform

  // Result registers, held until the next division completes (or reset).
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_start_acc;
  logic             w_b_zero;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dvs_ext;
  logic             w_ge;
  logic [WIDTH:0]   w_prem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_b_zero    = (b == '0);
  assign w_last      = (r_cnt == CW'(1));

  // One restoring step: bring in the next dividend bit, subtract the divisor if it fits.
  assign w_shift    = (r_prem << 1) | {{WIDTH{1'b0}}, r_dvd[WIDTH-1]};
  assign w_dvs_ext  = {1'b0, r_dvs};
  assign w_ge       = (w_shift >= w_dvs_ext);
  assign w_prem_nxt = w_ge ? (w_shift - w_dvs_ext) : w_shift;
  assign w_quo_nxt  = (r_quo_work << 1) | {{(WIDTH-1){1'b0}}, w_ge};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_b_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, step in CALC, publish results on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_quo_work <= '0;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
    end else if (w_start_acc) begin
      r_dvd      <= a;
      r_dvs      <= b;
      r_prem     <= '0;
      r_quo_work <= '0;
      r_cnt      <= CNT_INIT;
      r_dbz      <= w_b_zero;
      // A zero divisor skips CALC entirely, so its results are published right here.
      if (w_b_zero) begin
        r_quo <= '1;
        r_rem <= a;
      end
    end else if (r_state == S_CALC) begin
      r_dvd      <= r_dvd << 1;
      r_prem     <= w_prem_nxt;
      r_quo_work <= w_quo_nxt;
      r_cnt      <= r_cnt - CW'(1);
      if (w_last) begin
        r_quo <= w_quo_nxt;
        r_rem <= w_prem_nxt[WIDTH-1:0];
      end
    end
  end

  assign div_by_zero = r_dbz;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign out         = PB0 ? {r_quo, r_rem} : {r_rem, r_quo};

endmodule

// File: tb/tb_seq_div_2bit.sv
// Directed bench for seq_div_2bit (WIDTH=2): vector table plus hand-written multi-cycle sequences.
// Outputs are sampled 1ns after the rising edge; inputs change at the same point.
// Covers reset, latency, div-by-zero, busy-ignore, reset abort and a held-start exhaustive sweep.
module tb_seq_div_2bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] a;
  logic [1:0] b;
  logic       PB0;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [1:0] quotient;
  logic [1:0] remainder;
  logic [3:0] out;

  int n_cmp;
  int n_err;

  seq_div_2bit #(.WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .PB0         (PB0),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] q;
    logic [1:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Waits (bounded) for IDLE, launches one division with a single-cycle start, and
  // returns the number of edges from the sampling edge until done is seen (10 = timeout).
  task automatic run_div(input logic [1:0] ta, input logic [1:0] tb_v, output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nd;
    int k;
    logic [1:0] eq;
    logic [1:0] er;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; a = 2'd0; b = 2'd0; PB0 = 1'b0;

    // Expected values worked out by hand.
    vecs[0] = '{a: 2'd3, b: 2'd2, q: 2'd1, r: 2'd1, dbz: 1'b0, lat: 3};
    vecs[1] = '{a: 2'd3, b: 2'd1, q: 2'd3, r: 2'd0, dbz: 1'b0, lat: 3};
    vecs[2] = '{a: 2'd1, b: 2'd3, q: 2'd0, r: 2'd1, dbz: 1'b0, lat: 3};
    vecs[3] = '{a: 2'd0, b: 2'd1, q: 2'd0, r: 2'd0, dbz: 1'b0, lat: 3};
    vecs[4] = '{a: 2'd2, b: 2'd3, q: 2'd0, r: 2'd2, dbz: 1'b0, lat: 3};
    vecs[5] = '{a: 2'd2, b: 2'd0, q: 2'd3, r: 2'd2, dbz: 1'b1, lat: 1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    chk("rst_quo", 32'(quotient), 0);
    chk("rst_rem", 32'(remainder), 0);
    chk("rst_out", 32'(out), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_quo", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d_rem", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      PB0 = 1'b0; #1;
      chk($sformatf("v%0d_out_pb0", i), 32'(out), 32'({vecs[i].r, vecs[i].q}));
      PB0 = 1'b1; #1;
      chk($sformatf("v%0d_out_pb1", i), 32'(out), 32'({vecs[i].q, vecs[i].r}));
      PB0 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_width", i), 32'(done), 0);
    end

    // Accepting a valid start clears div_by_zero at once, old results stay until done.
    a = 2'd3; b = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dbz_clear", 32'(div_by_zero), 0);
    chk("dbz_hold_quo", 32'(quotient), 3);
    chk("dbz_hold_rem", 32'(remainder), 2);
    k = 0;
    while (!done && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("dbz_next_quo", 32'(quotient), 3);
    chk("dbz_next_rem", 32'(remainder), 0);
    @(posedge clk); #1;

    // A second start while busy is dropped: exactly one done, results of the first request.
    a = 2'd1; b = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    a = 2'd3; b = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("busy_ignore_dones", 32'(nd), 1);
    chk("busy_ignore_quo", 32'(quotient), 0);
    chk("busy_ignore_rem", 32'(remainder), 1);

    // Reset during CALC aborts the division: everything to 0, no done afterwards.
    a = 2'd3; b = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    chk("abort_quo", 32'(quotient), 0);
    chk("abort_rem", 32'(remainder), 0);
    chk("abort_out", 32'(out), 0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(nd), 0);
    run_div(2'd2, 2'd1, lat);
    chk("post_abort_latency", 32'(lat), 3);
    chk("post_abort_quo", 32'(quotient), 2);
    chk("post_abort_rem", 32'(remainder), 0);
    @(posedge clk); #1;

    // Exhaustive sweep with start held high; check results and done-to-done spacing.
    start = 1'b1;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        a = 2'(ia); b = 2'(ib);
        k = 0;
        do begin
          @(posedge clk); #1;
          k++;
        end while (!done && k < 10);
        if (ib == 0) begin
          eq = 2'd3;
          er = 2'(ia);
        end else begin
          eq = 2'(ia / ib);
          er = 2'(ia % ib);
        end
        chk($sformatf("sweep_%0d_%0d_done", ia, ib), 32'(done), 1);
        chk($sformatf("sweep_%0d_%0d_quo", ia, ib), 32'(quotient), 32'(eq));
        chk($sformatf("sweep_%0d_%0d_rem", ia, ib), 32'(remainder), 32'(er));
        chk($sformatf("sweep_%0d_%0d_dbz", ia, ib), 32'(div_by_zero), (ib == 0) ? 1 : 0);
        if (ia != 0 || ib != 0)
          chk($sformatf("sweep_%0d_%0d_spacing", ia, ib), 32'(k), (ib == 0) ? 2 : 4);
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
